// File: rtl/rd_burst_sequencer.sv
// rd_burst_sequencer: turns one CPU read request into a single DRAM read burst.
// The request is acknowledged and its burst-aligned address is issued as a command.
// After CL cycles, BL/2 captured words are assembled into one line and returned to the CPU.
// Latency: ack at T, command at T+1 (if ready), line valid at T+1+CL+BL/2.
// Backpressure: cmd_valid_o holds until cmd_ready_i, and rd_valid_o holds until rd_ready_i.
// A request made while busy_o is high is not acknowledged.
//
// Ports:
//   clock_i, reset_n_i               clock, asynchronous active-low reset
//   cpu_rd_req_i, cpu_addr_i         CPU read request and address
//   cpu_rd_ack_o                     one-cycle acceptance pulse
//   cmd_valid_o, cmd_addr_o          read command to the DRAM command path
//   cmd_ready_i                      command path accept
//   burst_data_i                     one captured DDR word per clock
//   rd_data_o, rd_valid_o            assembled burst line to the CPU
//   rd_ready_i                       CPU accept
//   busy_o                           high whenever not idle
module rd_burst_sequencer #(
  parameter int BW = 16,
  parameter int BL = 8,
  parameter int CL = 5,
  parameter int AW = 16
) (
  input  logic                   clock_i,
  input  logic                   reset_n_i,
  input  logic                   cpu_rd_req_i,
  input  logic [AW-1:0]          cpu_addr_i,
  output logic                   cpu_rd_ack_o,
  output logic                   cmd_valid_o,
  output logic [AW-1:0]          cmd_addr_o,
  input  logic                   cmd_ready_i,
  input  logic [BW-1:0]          burst_data_i,
  output logic [BW*(BL/2)-1:0]   rd_data_o,
  output logic                   rd_valid_o,
  input  logic                   rd_ready_i,
  output logic                   busy_o
);

  localparam int NW   = BL / 2;
  localparam int CMAX = (CL > NW) ? CL : NW;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam int OB   = $clog2(BL);
  // Clears the address bits that select a beat within the burst.
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'((1 << OB) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WAIT_CL,
    S_CAPTURE,
    S_DELIVER
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        lat_cnt_q, lat_cnt_d;
  logic [CW-1:0]        word_cnt_q, word_cnt_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [BW*NW-1:0]     rd_data_q, rd_data_d;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= S_IDLE;
      lat_cnt_q  <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    word_cnt_d   = word_cnt_q;
    addr_d       = addr_q;
    rd_data_d    = rd_data_q;
    cpu_rd_ack_o = 1'b0;
    cmd_valid_o  = 1'b0;
    rd_valid_o   = 1'b0;
    busy_o       = 1'b1;

    case (state_q)
      S_IDLE: begin
        busy_o = 1'b0;
        if (cpu_rd_req_i) begin
          // The ack is combinational from IDLE. It is gated so that it stays
          // low while reset is asserted and the state is forced to IDLE.
          cpu_rd_ack_o = reset_n_i;
          addr_d       = cpu_addr_i & ALIGN_MASK;
          state_d      = S_CMD;
        end
      end

      S_CMD: begin
        cmd_valid_o = 1'b1;
        if (cmd_ready_i) begin
          lat_cnt_d  = CW'(CL - 1);
          word_cnt_d = '0;
          // With CL=1, the first word is sampled on the very next edge.
          // In that case there is nothing to wait for.
          if (CL == 1) begin
            state_d = S_CAPTURE;
          end else begin
            state_d = S_WAIT_CL;
          end
        end
      end

      S_WAIT_CL: begin
        lat_cnt_d = lat_cnt_q - CW'(1);
        // Leave while the count steps 1 -> 0.
        // This makes the first CAPTURE edge exactly CL edges after the handshake.
        if (lat_cnt_q == CW'(1)) begin
          state_d = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        for (int k = 0; k < NW; k++) begin
          if (word_cnt_q == CW'(k)) begin
            rd_data_d[BW*k +: BW] = burst_data_i;
          end
        end
        if (word_cnt_q == CW'(NW - 1)) begin
          word_cnt_d = '0;
          state_d    = S_DELIVER;
        end else begin
          word_cnt_d = word_cnt_q + CW'(1);
        end
      end

      S_DELIVER: begin
        rd_valid_o = 1'b1;
        if (rd_ready_i) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cmd_addr_o = addr_q;
  assign rd_data_o  = rd_data_q;

endmodule
